nat_split_n_df: RTL

Clocked, parametrised N-way unconditional split with data and per-branch buffering. One input word is copied into every output branch. Each branch drains through its own FIFO, so a slow consumer does not stall the others until its FIFO fills. Each output holds its last delivered word after the branch drains. The block sits between pipeline stages wherever one producer feeds several independent consumers.

---
 rtl/nat_split_pkg.sv | 24 ++
 rtl/nat_split_fifo.sv | 72 +++++++
 rtl/nat_split_n_df.sv | 68 ++++++
 3 files changed

// File: rtl/nat_split_pkg.sv
// Shared helpers for the N-way split: pointer/count widths and config legality.
package nat_split_pkg;

    // Width of a FIFO read/write pointer that wraps modulo depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of an occupancy count that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

    // True when depth is a power of two and at least 2.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // True when the branch count / depth combination is legal.
    function automatic bit cfg_ok(input int num_out, input int depth);
        return (num_out >= 2) && depth_ok(depth);
    endfunction

endpackage

// File: rtl/nat_split_fifo.sv
// One branch of the split: circular FIFO with head bypass to output, plus a
// register that holds the last delivered word once the branch runs empty.
module nat_split_fifo
    import nat_split_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr_reg;
    logic [PW-1:0]         wr_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [DATA_WIDTH-1:0] last_reg;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;
    logic [DATA_WIDTH-1:0] head;

    // Flags come straight from the registered count; a pop in the same edge
    // never frees a slot for a push (no bypass around a full FIFO).
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = !empty && ready;
    assign head    = mem[rd_ptr_reg];
    assign valid   = !empty;
    assign data    = empty ? last_reg : head;

    // Storage write; contents are don't-care until counted, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, occupancy and last-delivered word; reset discards everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            last_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
                last_reg   <= head;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/nat_split_n_df.sv
// N-way unconditional split with a FIFO per branch.
// Optional per-word branch select enabled by defining NAT_SPLIT_MASK_EN.
module nat_split_n_df
    import nat_split_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 2,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_drive,
    output logic                          o_free,
    input  logic [DATA_WIDTH-1:0]         i_data,
`ifdef NAT_SPLIT_MASK_EN
    input  logic [NUM_OUT-1:0]            i_mask,
`endif
    output logic [NUM_OUT-1:0]            o_driveNext,
    input  logic [NUM_OUT-1:0]            i_freeNext,
    output logic [NUM_OUT*DATA_WIDTH-1:0] o_data
);

    localparam bit CFG_OK = cfg_ok(NUM_OUT, DEPTH);

    // Illegal branch count or non-power-of-two depth stops elaboration.
    generate
        if (!CFG_OK) begin : g_cfg_illegal
            $error("nat_split_n_df: NUM_OUT must be >= 2 and DEPTH a power of two >= 2");
        end
    endgenerate

    logic [NUM_OUT-1:0] sel;
    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] push;
    logic               accept;

`ifdef NAT_SPLIT_MASK_EN
    assign sel = i_mask;
`else
    assign sel = '1;
`endif

    // Accept only when every selected branch has room; consumer readiness
    // never enters this path, only registered FIFO state (and the mask).
    assign o_free = &(~full | ~sel);
    assign accept = i_drive && o_free;
    assign push   = {NUM_OUT{accept}} & sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_branch
            nat_split_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (push[gi]),
                .push_data (i_data),
                .ready     (i_freeNext[gi]),
                .valid     (o_driveNext[gi]),
                .full      (full[gi]),
                .data      (o_data[gi*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule
